multicycle_ctrl: RTL

Multi-cycle sequencer for the RV32I-subset datapath: walks each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives the per-cycle datapath enables. It sits beside the combinational decode control unit and consumes the same opcode classes: R-format, I-format, LD, ST, BEQ and JAL. It also owns the shared instruction/data memory port through a req/ready handshake and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset datapath.
// Drives per-cycle datapath enables, owns the shared memory handshake and counts retires.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] C_R   = 3'd0;
    localparam logic [2:0] C_I   = 3'd1;
    localparam logic [2:0] C_LD  = 3'd2;
    localparam logic [2:0] C_ST  = 3'd3;
    localparam logic [2:0] C_BEQ = 3'd4;
    localparam logic [2:0] C_JAL = 3'd5;
    localparam logic [2:0] C_BAD = 3'd6;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       cls;
    logic [2:0]       cls_nxt;
    logic [2:0]       dec_cls;
    logic [CNT_W-1:0] cnt;

    // Opcode to class; only consulted in DECODE.
    always_comb begin
        case (opcode)
            OP_R:    dec_cls = C_R;
            OP_I:    dec_cls = C_I;
            OP_LD:   dec_cls = C_LD;
            OP_ST:   dec_cls = C_ST;
            OP_BEQ:  dec_cls = C_BEQ;
            OP_JAL:  dec_cls = C_JAL;
            default: dec_cls = C_BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cls   <= C_R;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cls   <= cls_nxt;
            if (retire) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next state and outputs; everything held at 0 while reset is asserted.
    always_comb begin
        state_nxt = state;
        cls_nxt   = cls;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        retire    = 1'b0;
        illegal   = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
                    cls_nxt   = dec_cls;
                    state_nxt = (dec_cls == C_BAD) ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    alu_src = (cls == C_I) || (cls == C_LD) || (cls == C_ST);
                    case (cls)
                        C_BEQ: begin
                            pc_write  = 1'b1;
                            pc_src    = zero;
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end
                        C_LD, C_ST: state_nxt = S_MEM;
                        default:    state_nxt = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (cls == C_ST);
                    alu_src = 1'b1;
                    if (mem_ready) begin
                        if (cls == C_ST) begin
                            pc_write  = 1'b1;
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                    case (cls)
                        C_LD:    wb_sel = 2'd1;
                        C_JAL: begin
                            wb_sel = 2'd2;
                            pc_src = 1'b1;
                        end
                        default: wb_sel = 2'd0;
                    endcase
                end
                S_TRAP:  illegal = 1'b1;
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    assign instr_count = rst_n ? cnt : '0;

endmodule
